// File: rtl/disp_scan_4dig.sv
// disp_scan_4dig: time-multiplexed 4-digit hex display scanner.
// Incoming data is staged in a pending register and moved into the display
// register only at a frame boundary, so a frame never mixes old and new digits.
module disp_scan_4dig #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned LZB = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  output logic        ready,
  output logic        ack,
  output logic [3:0]  nibble,
  output logic [3:0]  an,
  output logic        frame
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    dsel_q, dsel_d;
  logic [15:0]   disp_q, disp_d;
  logic [15:0]   pend_q, pend_d;
  logic          pvalid_q, pvalid_d;
  logic          ack_q, ack_d;
  logic          frame_q, frame_d;
  logic [3:0]    nibble_q, nibble_d;
  logic [3:0]    an_q, an_d;

  logic          tick;
  logic          boundary;
  logic [3:0]    zero_from;
  logic          blank;

  // Next-state logic: prescaler, digit index, pending/display handoff and
  // registered scan outputs. Outputs are computed from the next disp/dsel so
  // they change in the same cycle as the state they describe.
  always_comb begin
    tick     = (pcnt_q == PMAX);
    boundary = tick && (dsel_q == 2'd3);

    pcnt_d   = tick ? '0 : pcnt_q + PW'(1);
    dsel_d   = tick ? dsel_q + 2'd1 : dsel_q;

    disp_d   = disp_q;
    pend_d   = pend_q;
    pvalid_d = pvalid_q;
    ack_d    = 1'b0;

    // A load in the transfer cycle sees ready=0 and is dropped.
    if (boundary && pvalid_q) begin
      disp_d   = pend_q;
      pvalid_d = 1'b0;
      ack_d    = 1'b1;
    end else if (load && !pvalid_q) begin
      pend_d   = data;
      pvalid_d = 1'b1;
    end

    frame_d  = boundary;
    nibble_d = disp_d[{dsel_d, 2'b00} +: 4];

    // zero_from[k]: digits 3 down to k of the next display value are all zero.
    zero_from    = '0;
    zero_from[3] = (disp_d[15:12] == 4'h0);
    zero_from[2] = zero_from[3] && (disp_d[11:8] == 4'h0);
    zero_from[1] = zero_from[2] && (disp_d[7:4] == 4'h0);

    blank = (LZB != 0) && (dsel_d != 2'd0) && zero_from[dsel_d];
    an_d  = blank ? '1 : ~(4'b0001 << dsel_d);
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q   <= '0;
      dsel_q   <= '0;
      disp_q   <= '0;
      pend_q   <= '0;
      pvalid_q <= 1'b0;
      ack_q    <= 1'b0;
      frame_q  <= 1'b0;
      nibble_q <= '0;
      an_q     <= 4'b1110;
    end else begin
      pcnt_q   <= pcnt_d;
      dsel_q   <= dsel_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      pvalid_q <= pvalid_d;
      ack_q    <= ack_d;
      frame_q  <= frame_d;
      nibble_q <= nibble_d;
      an_q     <= an_d;
    end
  end

  assign ready  = !pvalid_q;
  assign ack    = ack_q;
  assign frame  = frame_q;
  assign nibble = nibble_q;
  assign an     = an_q;

endmodule

// File: tb/tb_disp_scan_4dig.sv
// Testbench for disp_scan_4dig: two instances (LZB=0 and LZB=1, DIV=4)
// share stimulus; a time-based reference model predicts every output and a
// scoreboard queue pairs accepted loads with the DUT's ack pulses.
module tb_disp_scan_4dig;

  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] data = '0;

  logic        ready0, ack0, frame0, ready1, ack1, frame1;
  logic [3:0]  nibble0, an0, nibble1, an1;

  disp_scan_4dig #(.DIV(DIV), .LZB(0)) u0 (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(ready0), .ack(ack0), .nibble(nibble0), .an(an0), .frame(frame0)
  );

  disp_scan_4dig #(.DIV(DIV), .LZB(1)) u1 (
    .clk(clk), .rst(rst), .load(load), .data(data),
    .ready(ready1), .ack(ack1), .nibble(nibble1), .an(an1), .frame(frame1)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: t is the index of the current cycle since reset
  // release; everything about the scan position follows from t.
  int          t        = 0;
  bit          armed    = 0;
  bit          m_pvalid = 0;
  logic [15:0] m_pend   = '0;
  logic [15:0] m_disp   = '0;
  bit          m_ack    = 0;
  int          m_acks   = 0;
  int          acks_seen = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s t=%0d got=%h expected=%h", nm, t, got, exp);
    end
  endtask

  // Model update at each active edge.
  always @(posedge clk) begin
    bit boundary;
    bit acc;
    if (rst) begin
      t = 0;
      m_pvalid = 0;
      m_pend = '0;
      m_disp = '0;
      m_ack = 0;
      exp_q.delete();
      armed = 1;
    end else begin
      boundary = (t % FRAME) == FRAME - 1;
      acc      = load && !m_pvalid;
      m_ack    = boundary && m_pvalid;
      if (m_ack) begin
        m_disp   = m_pend;
        m_pvalid = 0;
        m_acks++;
      end
      if (acc) begin
        m_pend   = data;
        m_pvalid = 1;
        exp_q.push_back(data);
      end
      t++;
    end
  end

  // Monitor: compares both DUTs against the model away from the active edge.
  always @(negedge clk) begin
    int          d;
    logic [3:0]  e_nib, e_an0, e_an1;
    logic [15:0] shown;
    if (armed) begin
      d     = (t / DIV) % 4;
      e_nib = 4'((m_disp >> (4 * d)) & 16'hF);
      e_an0 = ~(4'b0001 << d);
      e_an1 = (d != 0 && (m_disp >> (4 * d)) == 0) ? 4'b1111 : e_an0;
      chk("ready0", 32'(ready0), 32'(!m_pvalid));
      chk("ready1", 32'(ready1), 32'(!m_pvalid));
      chk("ack0", 32'(ack0), 32'(m_ack));
      chk("ack1", 32'(ack1), 32'(m_ack));
      chk("frame0", 32'(frame0), 32'((t % FRAME == 0) && t != 0));
      chk("frame1", 32'(frame1), 32'((t % FRAME == 0) && t != 0));
      chk("nibble0", 32'(nibble0), 32'(e_nib));
      chk("nibble1", 32'(nibble1), 32'(e_nib));
      chk("an0", 32'(an0), 32'(e_an0));
      chk("an1", 32'(an1), 32'(e_an1));
      chk("an1_onehot", 32'($countones(~an1) <= 1), 32'd1);
      if (ack0) begin
        acks_seen++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_ack", 32'd1, 32'd0);
        end else begin
          shown = exp_q.pop_front();
          chk("sb_digit0", 32'(nibble0), 32'(shown[3:0]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input int hold);
    load = 1'b1;
    data = v;
    cyc(hold);
    load = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    load = 1'b1;              // ignored while in reset
    data = 16'hDEAD;
    cyc(3);
    load = 1'b0;
    rst = 1'b0;
    cyc(40);                  // free-run scan, nibble 0

    cyc(5);
    do_load(16'h1A2F, 1);     // mid-frame load
    cyc(40);

    do_load(16'h1234, 1);
    do_load(16'h5678, 3);     // dropped while pending
    cyc(40);

    do_load(16'h0050, 1);     // leading-zero blanking
    cyc(40);
    do_load(16'h0000, 1);
    cyc(40);

    do_load(16'hBEEF, 1);     // reset discards pending value
    cyc(2);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(40);

    // Load in the boundary cycle while nothing is pending.
    while ((t % FRAME) != FRAME - 1) cyc(1);
    load = 1'b1;
    data = 16'hC0DE;
    cyc(1);
    load = 1'b0;
    n = 0;
    while (!ack0 && n < 40) begin
      cyc(1);
      n++;
    end
    chk("coincident_ack_delay", 32'(n), 32'd16);
    cyc(20);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 800; i++) begin
      load = ($urandom_range(0, 3) == 0);
      data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:8] = 8'h00;
      rst  = ($urandom_range(0, 149) == 0);
      cyc(1);
    end
    load = 1'b0;
    rst  = 1'b0;
    cyc(2 * FRAME);

    chk("ack_count", 32'(acks_seen), 32'(m_acks));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
